// File: rtl/imem_refill_responder.sv
// I-cache line-refill responder: fixed-latency wait, then word-by-word reads from a
// synchronous imem returned as a valid/ready beat stream. Optional: IMEM_CRITICAL_WORD_FIRST_EN.
module imem_refill_responder #(
    parameter int PC_W       = 16,
    parameter int WORD_W     = 16,
    parameter int LINE_WORDS = 4,
    parameter int LATENCY    = 3
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          flush,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [PC_W-1:0]               req_addr,
    output logic                          mem_rd_en,
    output logic [PC_W-1:0]               mem_rd_addr,
    input  logic [WORD_W-1:0]             mem_rd_data,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [WORD_W-1:0]             resp_data,
    output logic [$clog2(LINE_WORDS)-1:0] resp_beat,
    output logic                          resp_last,
    output logic                          busy
);

    localparam int OW = $clog2(LINE_WORDS);
    localparam int CW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

    state_t            state, state_nxt;
    logic [PC_W-1:0]   base_q;
    logic [OW-1:0]     start_q, start_d, rd_off;
    logic [OW:0]       issue_cnt;
    logic [CW-1:0]     lat_cnt;
    logic              ready_en_q;
    logic              fresh_q;
    logic              valid_q;
    logic [WORD_W-1:0] hold_q;
    logic [OW-1:0]     beat_q;
    logic              last_q;
    logic              accept;
    logic              issue_left;
    logic              beat_done;

    always_comb begin
        start_d = '0;
`ifdef IMEM_CRITICAL_WORD_FIRST_EN
        start_d = req_addr[OW-1:0];
`endif
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (accept) state_nxt = (LATENCY == 0) ? BURST : WAIT;
                WAIT:    if (lat_cnt <= CW'(1)) state_nxt = BURST;
                BURST:   if (beat_done) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready   = (state == IDLE) && ready_en_q && !flush;
        accept      = req_valid && req_ready;
        issue_left  = issue_cnt < (OW+1)'(LINE_WORDS);
        // A new read always lands in the output stage on the same edge, so it may
        // only issue when that stage is empty or being drained this cycle.
        mem_rd_en   = (state == BURST) && !flush && issue_left && (!valid_q || resp_ready);
        rd_off      = start_q + issue_cnt[OW-1:0];
        mem_rd_addr = base_q | PC_W'(rd_off);
        beat_done   = valid_q && resp_ready && last_q;
        busy        = (state != IDLE) || valid_q;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ready_en_q <= 1'b0;
            fresh_q    <= 1'b0;
            hold_q     <= '0;
            base_q     <= '0;
            start_q    <= '0;
            issue_cnt  <= '0;
            lat_cnt    <= '0;
            valid_q    <= 1'b0;
            beat_q     <= '0;
            last_q     <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            fresh_q    <= mem_rd_en;
            if (fresh_q) hold_q <= mem_rd_data;
            if (flush) begin
                valid_q   <= 1'b0;
                beat_q    <= '0;
                last_q    <= 1'b0;
                issue_cnt <= '0;
                lat_cnt   <= '0;
            end else begin
                if (accept) begin
                    base_q    <= req_addr & ~PC_W'(LINE_WORDS - 1);
                    start_q   <= start_d;
                    issue_cnt <= '0;
                    lat_cnt   <= CW'(LATENCY);
                end else if (state == WAIT) begin
                    lat_cnt <= lat_cnt - 1'b1;
                end
                if (mem_rd_en) begin
                    valid_q   <= 1'b1;
                    beat_q    <= rd_off;
                    last_q    <= (issue_cnt == (OW+1)'(LINE_WORDS - 1));
                    issue_cnt <= issue_cnt + 1'b1;
                end else if (resp_ready) begin
                    valid_q <= 1'b0;
                end
            end
        end
    end

    // Memory output is live for one cycle after a read; afterwards the beat is
    // served from the local copy so it stays stable under backpressure.
    assign resp_valid = valid_q;
    assign resp_data  = !valid_q ? '0 : (fresh_q ? mem_rd_data : hold_q);
    assign resp_beat  = beat_q;
    assign resp_last  = last_q;

endmodule
